filter_buffer_ctrl: RTL and testbench

//  Responder side of the PE filter-buffer interface (fb_req_possible / fb_req / fb_addr / fb_data0..3).

---
 rtl/filter_buffer_ctrl_pkg.sv | 27 ++
 rtl/filter_buffer_ctrl_if.sv | 36 +++
 rtl/filter_bank_ram.sv | 27 ++
 rtl/filter_buffer_ctrl.sv | 120 ++++++++++++
 tb/tb_filter_buffer_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_buffer_ctrl_pkg.sv
// Filter buffer controller shared types and sizes.
// Imported by the bank RAM, bus interface and controller.
package filter_buffer_ctrl_pkg;

  localparam int TOUT          = 4;
  localparam int FILTER_DW     = 72;
  localparam int FILTER_BUF_AW = 10;
  localparam int BANK_W        = $clog2(TOUT);
  localparam int BEAT_W        = FILTER_BUF_AW + 3;

  typedef logic [FILTER_DW-1:0]     fb_word_t;
  typedef logic [FILTER_BUF_AW-1:0] fb_addr_t;
  typedef logic [FILTER_BUF_AW:0]   fb_len_t;
  typedef logic [BEAT_W-1:0]        fb_beat_t;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_LOAD  = 2'd1,
    FB_READY = 2'd2
  } fb_state_e;

  // Beats in a tile: one word per bank per tile row.
  function automatic fb_beat_t tile_beats(fb_len_t words);
    return fb_beat_t'(words) << BANK_W;
  endfunction

endpackage

// File: rtl/filter_buffer_ctrl_if.sv
// DMA write channel and PE read channel of the filter buffer.
// master = DMA/PE side, slave = filter_buffer_ctrl.
interface filter_buffer_ctrl_if;
  import filter_buffer_ctrl_pkg::*;

  logic     s_wr_vld;
  fb_word_t s_wr_data;
  logic     o_wr_rdy;
  logic     fb_req_possible;
  logic     fb_req;
  fb_addr_t fb_addr;
  fb_word_t fb_data0;
  fb_word_t fb_data1;
  fb_word_t fb_data2;
  fb_word_t fb_data3;
  logic     o_fb_data_vld;

  modport master (
    output s_wr_vld, s_wr_data,
    output fb_req, fb_addr,
    input  o_wr_rdy, fb_req_possible,
    input  fb_data0, fb_data1,
    input  fb_data2, fb_data3,
    input  o_fb_data_vld
  );

  modport slave (
    input  s_wr_vld, s_wr_data,
    input  fb_req, fb_addr,
    output o_wr_rdy, fb_req_possible,
    output fb_data0, fb_data1,
    output fb_data2, fb_data3,
    output o_fb_data_vld
  );

endinterface

// File: rtl/filter_bank_ram.sv
// One filter bank: single-port synchronous RAM, 1-cycle read.
// Read data holds while the port is idle or writing.
module filter_bank_ram #(
  parameter int DW = 72,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/filter_buffer_ctrl.sv
// Filter buffer responder: loads a tile from DMA across TOUT banks,
// then serves PE reads with one cycle of latency until released.
module filter_buffer_ctrl
  import filter_buffer_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_start,
  input  logic [FILTER_BUF_AW:0] i_load_words,
  input  logic                 i_release,
  output logic                 o_load_done,
  output logic                 o_rd_err,
  filter_buffer_ctrl_if.slave  bus
);

  fb_state_e state_q, state_d;
  fb_len_t   words_q;
  fb_beat_t  beat_q;
  logic [BANK_W-1:0] bank_q;
  fb_addr_t  waddr_q;
  logic      rdy_q;
  logic      done_q;
  logic      vld_q;
  logic      zero_q;
  logic      err_q;

  logic      wr_fire;
  logic      last_beat;
  logic      rd_ok;
  logic      rd_bad;
  logic      load_go;
  fb_addr_t  ram_addr;
  logic [TOUT-1:0] we;
  fb_word_t  rdata [TOUT];

  assign wr_fire   = bus.s_wr_vld && (state_q == FB_LOAD);
  assign last_beat = wr_fire &&
    (beat_q == tile_beats(words_q) - BEAT_W'(1));
  assign rd_ok     = bus.fb_req && (state_q == FB_READY) &&
    ({1'b0, bus.fb_addr} < words_q);
  assign rd_bad    = bus.fb_req && !rd_ok;
  assign load_go   = (state_q == FB_IDLE) && (state_d == FB_LOAD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FB_IDLE:
        if (i_load_start && (i_load_words != '0))
          state_d = FB_LOAD;
      FB_LOAD:
        if (last_beat) state_d = FB_READY;
      FB_READY:
        if (i_release) state_d = FB_IDLE;
      default: state_d = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FB_IDLE;
      words_q <= '0;
      beat_q  <= '0;
      bank_q  <= '0;
      waddr_q <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == FB_READY);
      done_q  <= last_beat;
      vld_q   <= bus.fb_req;
      if (load_go) begin
        words_q <= i_load_words;
        beat_q  <= '0;
        bank_q  <= '0;
        waddr_q <= '0;
      end else if (wr_fire) begin
        beat_q <= beat_q + BEAT_W'(1);
        bank_q <= bank_q + BANK_W'(1);
        if (bank_q == BANK_W'(TOUT - 1))
          waddr_q <= waddr_q + FILTER_BUF_AW'(1);
      end
      // Masks RAM output after an error read so data reads 0 and holds.
      if (bus.fb_req) zero_q <= rd_bad;
      if (rd_bad)            err_q <= 1'b1;
      else if (i_load_start) err_q <= 1'b0;
    end
  end

  assign ram_addr = (state_q == FB_LOAD) ? waddr_q : bus.fb_addr;

  for (genvar b = 0; b < TOUT; b++) begin : g_bank
    assign we[b] = wr_fire && (bank_q == BANK_W'(b));
    filter_bank_ram #(
      .DW(FILTER_DW),
      .AW(FILTER_BUF_AW)
    ) u_bank (
      .clk    (clk),
      .en_i   (we[b] || rd_ok),
      .we_i   (we[b]),
      .addr_i (ram_addr),
      .wdata_i(bus.s_wr_data),
      .rdata_o(rdata[b])
    );
  end

  assign bus.o_wr_rdy        = (state_q == FB_LOAD);
  assign bus.fb_req_possible = rdy_q;
  assign bus.o_fb_data_vld   = vld_q;
  assign bus.fb_data0 = zero_q ? '0 : rdata[0];
  assign bus.fb_data1 = zero_q ? '0 : rdata[1];
  assign bus.fb_data2 = zero_q ? '0 : rdata[2];
  assign bus.fb_data3 = zero_q ? '0 : rdata[3];
  assign o_load_done  = done_q;
  assign o_rd_err     = err_q;

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// Self-checking bench for filter_buffer_ctrl.
// Expected read data is queued at request time and popped on output.
module tb_filter_buffer_ctrl;
  import filter_buffer_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst;
  logic    load_start;
  fb_len_t load_words;
  logic    rel;
  logic    load_done;
  logic    rd_err;

  filter_buffer_ctrl_if bus();

  filter_buffer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_load_start(load_start),
    .i_load_words(load_words),
    .i_release   (rel),
    .o_load_done (load_done),
    .o_rd_err    (rd_err),
    .bus         (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [4*FILTER_DW-1:0] exp_q [$];
  logic [4*FILTER_DW-1:0] e;
  logic [4*FILTER_DW-1:0] held;
  logic [4*FILTER_DW-1:0] rd;
  fb_word_t mdl [4][16];
  int  mwords;
  bit  m_ready;
  bit  early;

  assign rd = {bus.fb_data3, bus.fb_data2,
               bus.fb_data1, bus.fb_data0};

  function automatic logic [4*FILTER_DW-1:0] expect_rd(int a);
    logic [4*FILTER_DW-1:0] v;
    v = '0;
    if (m_ready && a < mwords)
      v = {mdl[3][a], mdl[2][a], mdl[1][a], mdl[0][a]};
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int a);
    bus.fb_req  = 1'b1;
    bus.fb_addr = FILTER_BUF_AW'(a);
    exp_q.push_back(expect_rd(a));
  endtask

  task automatic beat(input int k, input int d);
    bus.s_wr_vld  = 1'b1;
    bus.s_wr_data = FILTER_DW'(d);
    mdl[k % 4][k / 4] = FILTER_DW'(d);
    step();
  endtask

  task automatic start(input int w);
    load_start = 1'b1;
    load_words = FILTER_BUF_AW'(w);
    step();
    load_start = 1'b0;
    mwords  = w;
    m_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    n_total++;
    if ({bus.o_wr_rdy, bus.fb_req_possible, bus.o_fb_data_vld,
         load_done, rd_err, rd} !== '0)
      $display("FAIL reset_outputs: rdy=%b poss=%b vld=%b done=%b err=%b data=%h want all 0",
               bus.o_wr_rdy, bus.fb_req_possible, bus.o_fb_data_vld,
               load_done, rd_err, rd);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_load;
    start(2);
    n_total++;
    if (bus.o_wr_rdy !== 1'b1)
      $display("FAIL load_wr_rdy: got %b want 1", bus.o_wr_rdy);
    else n_pass++;
    for (int k = 0; k < 7; k++) beat(k, k);
    n_total++;
    if (bus.fb_req_possible !== 1'b0 || load_done !== 1'b0)
      $display("FAIL load_early: poss=%b done=%b want 0 0",
               bus.fb_req_possible, load_done);
    else n_pass++;
    beat(7, 7);
    bus.s_wr_vld = 1'b0;
    m_ready = 1;
    n_total++;
    if (bus.fb_req_possible !== 1'b1 || load_done !== 1'b1 ||
        bus.o_wr_rdy !== 1'b0)
      $display("FAIL load_last: poss=%b done=%b rdy=%b want 1 1 0",
               bus.fb_req_possible, load_done, bus.o_wr_rdy);
    else n_pass++;
    step();
    n_total++;
    if (load_done !== 1'b0 || bus.fb_req_possible !== 1'b1)
      $display("FAIL load_done_pulse: done=%b poss=%b want 0 1",
               load_done, bus.fb_req_possible);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    req(0);
    step();
    e = exp_q.pop_front();
    n_total++;
    if (bus.o_fb_data_vld !== 1'b1 || rd !== e)
      $display("FAIL b2b_addr0: vld=%b data=%h want 1 %h",
               bus.o_fb_data_vld, rd, e);
    else n_pass++;
    req(1);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    held = e;
    n_total++;
    if (bus.o_fb_data_vld !== 1'b1 || rd !== e)
      $display("FAIL b2b_addr1: vld=%b data=%h want 1 %h",
               bus.o_fb_data_vld, rd, e);
    else n_pass++;
    step();
    n_total++;
    if (bus.o_fb_data_vld !== 1'b0 || rd !== held || rd_err !== 1'b0)
      $display("FAIL b2b_hold: vld=%b data=%h err=%b want 0 %h 0",
               bus.o_fb_data_vld, rd, rd_err, held);
    else n_pass++;
  endtask

  task automatic test_addr_range_err;
    req(2);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (bus.o_fb_data_vld !== 1'b1 || rd !== e || rd_err !== 1'b1)
      $display("FAIL range_err: vld=%b data=%h err=%b want 1 %h 1",
               bus.o_fb_data_vld, rd, rd_err, e);
    else n_pass++;
    step();
    n_total++;
    if (rd !== '0 || rd_err !== 1'b1 || bus.o_fb_data_vld !== 1'b0)
      $display("FAIL range_err_hold: data=%h err=%b vld=%b want 0 1 0",
               rd, rd_err, bus.o_fb_data_vld);
    else n_pass++;
    req(1);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (rd !== e || rd_err !== 1'b1)
      $display("FAIL err_sticky: data=%h err=%b want %h 1",
               rd, rd_err, e);
    else n_pass++;
    rel = 1'b1;
    step();
    rel = 1'b0;
    m_ready = 0;
    n_total++;
    if (bus.fb_req_possible !== 1'b0)
      $display("FAIL release: poss=%b want 0", bus.fb_req_possible);
    else n_pass++;
  endtask

  task automatic test_read_during_load;
    start(2);
    n_total++;
    if (rd_err !== 1'b0 || bus.o_wr_rdy !== 1'b1)
      $display("FAIL start_clears_err: err=%b rdy=%b want 0 1",
               rd_err, bus.o_wr_rdy);
    else n_pass++;
    for (int k = 0; k < 5; k++) beat(k, 100 + k);
    bus.s_wr_vld = 1'b0;
    req(0);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (bus.o_fb_data_vld !== 1'b1 || rd !== e || rd_err !== 1'b1)
      $display("FAIL load_read_err: vld=%b data=%h err=%b want 1 %h 1",
               bus.o_fb_data_vld, rd, rd_err, e);
    else n_pass++;
    beat(5, 105);
    beat(6, 106);
    req(0);
    beat(7, 107);
    bus.fb_req   = 1'b0;
    bus.s_wr_vld = 1'b0;
    e = exp_q.pop_front();
    m_ready = 1;
    n_total++;
    if (rd !== e || bus.o_fb_data_vld !== 1'b1 ||
        bus.fb_req_possible !== 1'b1 || load_done !== 1'b1)
      $display("FAIL last_beat_read: data=%h vld=%b poss=%b done=%b want %h 1 1 1",
               rd, bus.o_fb_data_vld, bus.fb_req_possible,
               load_done, e);
    else n_pass++;
    req(1);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (rd !== e)
      $display("FAIL reload_addr1: data=%h want %h", rd, e);
    else n_pass++;
    rel = 1'b1;
    step();
    rel = 1'b0;
    m_ready = 0;
  endtask

  task automatic test_reset_mid_load;
    start(2);
    for (int k = 0; k < 3; k++) beat(k, 300 + k);
    bus.s_wr_vld = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if ({bus.o_wr_rdy, bus.fb_req_possible, bus.o_fb_data_vld,
         load_done, rd_err, rd} !== '0)
      $display("FAIL mid_reset: rdy=%b poss=%b vld=%b done=%b err=%b data=%h want all 0",
               bus.o_wr_rdy, bus.fb_req_possible, bus.o_fb_data_vld,
               load_done, rd_err, rd);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    start(2);
    early = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.fb_req_possible !== 1'b0) early = 1;
      beat(k, 200 + k);
    end
    bus.s_wr_vld = 1'b0;
    m_ready = 1;
    n_total++;
    if (early || bus.fb_req_possible !== 1'b1)
      $display("FAIL restart_load: early=%0d poss=%b want 0 1",
               early, bus.fb_req_possible);
    else n_pass++;
    req(0);
    step();
    e = exp_q.pop_front();
    n_total++;
    if (rd !== e)
      $display("FAIL restart_addr0: data=%h want %h", rd, e);
    else n_pass++;
    req(1);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (rd !== e)
      $display("FAIL restart_addr1: data=%h want %h", rd, e);
    else n_pass++;
  endtask

  task automatic test_release_with_read;
    rel = 1'b1;
    req(1);
    step();
    rel = 1'b0;
    bus.fb_req = 1'b0;
    m_ready = 0;
    e = exp_q.pop_front();
    n_total++;
    if (bus.o_fb_data_vld !== 1'b1 || rd !== e ||
        bus.fb_req_possible !== 1'b0)
      $display("FAIL release_read: vld=%b data=%h poss=%b want 1 %h 0",
               bus.o_fb_data_vld, rd, bus.fb_req_possible, e);
    else n_pass++;
    start(1);
    n_total++;
    if (bus.o_wr_rdy !== 1'b1)
      $display("FAIL restart_after_release: rdy=%b want 1",
               bus.o_wr_rdy);
    else n_pass++;
    for (int k = 0; k < 4; k++) beat(k, 500 + k);
    bus.s_wr_vld = 1'b0;
    m_ready = 1;
    req(0);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (rd !== e || bus.fb_req_possible !== 1'b1)
      $display("FAIL one_word_tile: data=%h poss=%b want %h 1",
               rd, bus.fb_req_possible, e);
    else n_pass++;
    req(1);
    step();
    bus.fb_req = 1'b0;
    e = exp_q.pop_front();
    n_total++;
    if (rd !== e || rd_err !== 1'b1)
      $display("FAIL one_word_range: data=%h err=%b want %h 1",
               rd, rd_err, e);
    else n_pass++;
    rel = 1'b1;
    step();
    rel = 1'b0;
    m_ready = 0;
    start(0);
    n_total++;
    if (bus.o_wr_rdy !== 1'b0)
      $display("FAIL zero_words: rdy=%b want 0", bus.o_wr_rdy);
    else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    load_start   = 1'b0;
    load_words   = '0;
    rel          = 1'b0;
    bus.s_wr_vld  = 1'b0;
    bus.s_wr_data = '0;
    bus.fb_req    = 1'b0;
    bus.fb_addr   = '0;
    mwords  = 0;
    m_ready = 0;
    test_reset();
    test_load();
    test_back_to_back();
    test_addr_range_err();
    test_read_during_load();
    test_reset_mid_load();
    test_release_with_read();
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
